// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types and arbiter state encoding.
// Purely declarative: no latency, no backpressure of its own.
package cbus_arbiter_pkg;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } cbus_size_t;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        cbus_size_t size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_REQ = 8;

    // Grant index width; at least one bit so a single port still has a legal index.
    function automatic int arb_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_pick.sv
// Combinational winner selection for cbus_arbiter; zero latency, never stalls.
// CBUS_ARB_ROUND_ROBIN_EN selects round-robin, otherwise highest valid index wins.
module cbus_arb_pick
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = arb_idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic [IDX_BITS-1:0] i_last_grant,
    output logic [IDX_BITS-1:0] o_winner,
    output logic                o_any_valid
);

    assign o_any_valid = |i_valid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_BITS-1:0] w_k;
    logic                w_found;

    // Walk NUM_REQ slots starting just after the previous owner; the previous
    // owner itself is visited last, so it only wins when nobody else asks.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_k      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = IDX_BITS'((int'(i_last_grant) + i) % NUM_REQ);
            if (!w_found && i_valid[w_k]) begin
                o_winner = w_k;
                w_found  = 1'b1;
            end
        end
    end
`else
    logic [IDX_BITS-1:0] w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    always_comb begin
        o_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_valid[i]) begin
                o_winner = IDX_BITS'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one cbus among NUM_REQ caches; 1-cycle arbitration, grant locked for the burst.
// Losers see zero responses and stall; CBUS_ARB_ROUND_ROBIN_EN selects round-robin.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       busy
);

    localparam int IDX_BITS = arb_idx_bits(NUM_REQ);

    arb_state_t          r_state;
    logic [IDX_BITS-1:0] r_index;
    logic [IDX_BITS-1:0] r_last_grant;

    logic [NUM_REQ-1:0]  w_valid;
    logic [IDX_BITS-1:0] w_winner;
    logic                w_any_valid;
    logic                w_active;
    cbus_req_t           w_gnt_req;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_valid
        assign w_valid[g] = ireqs[g].valid;
    end

    cbus_arb_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_pick (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_valid  (w_any_valid)
    );

    assign w_gnt_req = ireqs[r_index];

    // Gating with resetn keeps the bus quiet in the very cycle reset is asserted,
    // before the state register has had a chance to fall back to IDLE.
    assign w_active = resetn && (r_state == BUSY);
    assign busy     = w_active;
    assign oreq     = w_active ? w_gnt_req : '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
        assign iresps[g] = (w_active && (r_index == IDX_BITS'(g))) ? oresp : '0;
    end

    // Every exit from BUSY lands in IDLE for at least one cycle, which is the
    // bubble that lets the finishing requester drop valid before re-arbitration.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_last_grant <= IDX_BITS'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_index <= w_winner;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_index;
                    end else if (!w_gnt_req.valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter (2 ports).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int NUM_REQ = 2;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  ireqs  [NUM_REQ];
    cbus_resp_t iresps [NUM_REQ];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    cbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr, input cbus_len_t len,
                                         input logic [31:0] data, input logic [3:0] strobe);
        cbus_req_t r;
        r.valid = 1'b1; r.is_write = wr; r.size = MSIZE4; r.addr = addr;
        r.strobe = strobe; r.data = data; r.len = len;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy; r.last = lst; r.data = d;
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; ireqs[0] = '0; ireqs[1] = '0; oresp = '0;
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++; if (oreq !== '0) begin n_fail++; $display("FAIL rst_oreq: got %h want 0", oreq); end
        n_tests++; if (iresps[0] !== '0 || iresps[1] !== '0) begin n_fail++; $display("FAIL rst_iresps: got %h/%h want 0", iresps[0], iresps[1]); end
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %b want IDLE", dut.r_state); end
        n_tests++; if (dut.r_index !== 1'b0) begin n_fail++; $display("FAIL rst_index: got %b want 0", dut.r_index); end
        n_tests++; if (dut.r_last_grant !== 1'b1) begin n_fail++; $display("FAIL rst_last_grant: got %b want 1", dut.r_last_grant); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ireqs[0] = mk_req(1'b0, 32'h8000_0000, MLEN4, 32'h0, 4'h0); oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_arb_cycle_busy: got %b want 0", busy); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            oresp = mk_resp(1'b1, b == 3, 32'(32'h11 * (b + 1))); #1;
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sr_busy beat %0d: got %b want 1", b, busy); end
            n_tests++; if (oreq !== ireqs[0]) begin n_fail++; $display("FAIL sr_oreq beat %0d: got %h want %h", b, oreq, ireqs[0]); end
            n_tests++; if (iresps[0].data !== 32'(32'h11 * (b + 1)) || iresps[0].ready !== 1'b1)
                begin n_fail++; $display("FAIL sr_resp0 beat %0d: got %h want data %h ready 1", b, iresps[0], 32'(32'h11 * (b + 1))); end
            n_tests++; if (iresps[0].last !== (b == 3)) begin n_fail++; $display("FAIL sr_last beat %0d: got %b want %b", b, iresps[0].last, b == 3); end
            n_tests++; if (iresps[1] !== '0) begin n_fail++; $display("FAIL sr_resp1 beat %0d: got %h want 0", b, iresps[1]); end
        end
        @(negedge clk);
        ireqs[0] = '0; oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_bubble_busy: got %b want 0", busy); end
        n_tests++; if (iresps[0] !== '0 || iresps[1] !== '0) begin n_fail++; $display("FAIL sr_bubble_resp: got %h/%h want 0", iresps[0], iresps[1]); end
    endtask

    // Both ports collide after a completed port-0 burst: port 1 wins under either
    // policy (fixed: highest index; round-robin: search starts after port 0).
    task automatic test_collision();
        logic exp_busy;
        int   p;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ireqs[0] = mk_req(1'b0, 32'h0000_1000, MLEN4, 32'h0, 4'h0);
                ireqs[1] = mk_req(1'b0, 32'h0000_2000, MLEN4, 32'h0, 4'h0);
            end
            if (c == 5) ireqs[1] = '0;
            oresp = mk_resp(1'b1, (c == 4) || (c == 9), 32'(32'hC0 + c)); #1;
            exp_busy = !((c == 0) || (c == 5));
            p = (c < 5) ? 1 : 0;
            n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL col_busy cyc %0d: got %b want %b", c, busy, exp_busy); end
            if (exp_busy) begin
                n_tests++; if (oreq.addr !== (p == 1 ? 32'h0000_2000 : 32'h0000_1000))
                    begin n_fail++; $display("FAIL col_addr cyc %0d: got %h want port %0d", c, oreq.addr, p); end
                n_tests++; if (iresps[p].data !== 32'(32'hC0 + c)) begin n_fail++; $display("FAIL col_resp cyc %0d: got %h want %h", c, iresps[p].data, 32'(32'hC0 + c)); end
                n_tests++; if (iresps[1-p] !== '0) begin n_fail++; $display("FAIL col_loser cyc %0d: got %h want 0", c, iresps[1-p]); end
            end else begin
                n_tests++; if (oreq !== '0 || iresps[0] !== '0 || iresps[1] !== '0)
                    begin n_fail++; $display("FAIL col_idle cyc %0d: oreq %h resp %h/%h want 0", c, oreq, iresps[0], iresps[1]); end
            end
        end
        @(negedge clk);
        ireqs[0] = '0; oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL col_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_stall();
        logic [31:0] wd [6];
        logic        rd [6];
        logic        ls [6];
        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'hA3};
        rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        ireqs[1] = mk_req(1'b1, 32'h8000_1000, MLEN4, 32'hA0, 4'hF); oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_arb_busy: got %b want 0", busy); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ireqs[1].data = wd[c]; oresp = mk_resp(rd[c], ls[c], 32'h0); #1;
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy cyc %0d: got %b want 1", c, busy); end
            n_tests++; if (oreq !== ireqs[1] || oreq.data !== wd[c] || oreq.strobe !== 4'hF || oreq.is_write !== 1'b1)
                begin n_fail++; $display("FAIL wr_oreq cyc %0d: got %h want %h", c, oreq, ireqs[1]); end
            n_tests++; if (iresps[1].ready !== rd[c] || iresps[0] !== '0)
                begin n_fail++; $display("FAIL wr_resp cyc %0d: got rdy %b resp0 %h want rdy %b resp0 0", c, iresps[1].ready, iresps[0], rd[c]); end
        end
        @(negedge clk);
        ireqs[1] = '0; oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_abandon();
        @(negedge clk);
        ireqs[0] = mk_req(1'b0, 32'h0000_3000, MLEN4, 32'h0, 4'h0); oresp = '0; #1;
        @(negedge clk);
        oresp = mk_resp(1'b1, 1'b0, 32'h55);
        ireqs[1] = mk_req(1'b0, 32'h0000_4000, MLEN4, 32'h0, 4'h0); #1;
        n_tests++; if (busy !== 1'b1 || oreq.addr !== 32'h0000_3000) begin n_fail++; $display("FAIL ab_beat1: busy %b addr %h want 1/00003000", busy, oreq.addr); end
        n_tests++; if (iresps[1] !== '0) begin n_fail++; $display("FAIL ab_pending_resp: got %h want 0", iresps[1]); end
        @(negedge clk);
        ireqs[0] = '0; oresp = '0; #1;
        n_tests++; if (oreq.valid !== 1'b0) begin n_fail++; $display("FAIL ab_drop_valid: got %b want 0", oreq.valid); end
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b0 || oreq !== '0) begin n_fail++; $display("FAIL ab_idle: busy %b oreq %h want 0/0", busy, oreq); end
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b1 || oreq !== ireqs[1]) begin n_fail++; $display("FAIL ab_regrant: busy %b oreq %h want 1/%h", busy, oreq, ireqs[1]); end
        @(negedge clk);
        ireqs[1] = '0;
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_end_busy: got %b want 0", busy); end
    endtask

    // Both ports request continuously from a fresh reset; MLEN1 bursts complete
    // in their single BUSY cycle, so BUSY and IDLE alternate.
    task automatic test_continuous();
        int exp_order [3];
        int p;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{1, 1, 1};
`endif
        @(negedge clk);
        resetn = 1'b0; ireqs[0] = '0; ireqs[1] = '0; oresp = '0;
        @(negedge clk);
        resetn = 1'b1;
        ireqs[0] = mk_req(1'b0, 32'h0000_5000, MLEN1, 32'h0, 4'h0);
        ireqs[1] = mk_req(1'b0, 32'h0000_6000, MLEN1, 32'h0, 4'h0);
        oresp = mk_resp(1'b1, 1'b1, 32'h77);
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (c % 2 == 0) begin
                n_tests++; if (busy !== 1'b0 || iresps[0] !== '0 || iresps[1] !== '0)
                    begin n_fail++; $display("FAIL cont_idle cyc %0d: busy %b resp %h/%h want 0", c, busy, iresps[0], iresps[1]); end
            end else begin
                p = exp_order[c / 2];
                n_tests++; if (busy !== 1'b1 || oreq.addr !== (p == 1 ? 32'h0000_6000 : 32'h0000_5000))
                    begin n_fail++; $display("FAIL cont_grant burst %0d: busy %b addr %h want port %0d", c / 2, busy, oreq.addr, p); end
                n_tests++; if (iresps[p].last !== 1'b1 || iresps[1-p] !== '0)
                    begin n_fail++; $display("FAIL cont_resp burst %0d: winner last %b loser %h want 1/0", c / 2, iresps[p].last, iresps[1-p]); end
            end
        end
        @(negedge clk);
        ireqs[0] = '0; ireqs[1] = '0; oresp = '0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        ireqs[0] = mk_req(1'b0, 32'h0000_7000, MLEN4, 32'h0, 4'h0); oresp = '0;
        @(negedge clk);
        oresp = mk_resp(1'b1, 1'b0, 32'h61); #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_beat1_busy: got %b want 1", busy); end
        @(negedge clk);
        oresp = mk_resp(1'b1, 1'b0, 32'h62); resetn = 1'b0; #1;
        n_tests++; if (busy !== 1'b0 || oreq !== '0 || iresps[0] !== '0)
            begin n_fail++; $display("FAIL rm_during_reset: busy %b oreq %h resp0 %h want 0", busy, oreq, iresps[0]); end
        @(negedge clk);
        resetn = 1'b1; ireqs[0] = '0; oresp = '0; #1;
        n_tests++; if (busy !== 1'b0 || oreq !== '0 || iresps[0] !== '0 || iresps[1] !== '0)
            begin n_fail++; $display("FAIL rm_after_reset: busy %b oreq %h resp %h/%h want 0", busy, oreq, iresps[0], iresps[1]); end
        n_tests++; if (dut.r_state !== IDLE || dut.r_index !== 1'b0 || dut.r_last_grant !== 1'b1)
            begin n_fail++; $display("FAIL rm_regs: state %b index %b last_grant %b want IDLE/0/1", dut.r_state, dut.r_index, dut.r_last_grant); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; ireqs[0] = '0; ireqs[1] = '0; oresp = '0;
        test_reset();
        test_single_read();
        test_collision();
        test_write_stall();
        test_abandon();
        test_continuous();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single cache-side memory bus (cbus) between NUM_REQ requesters, e.g. ICache (port 0) and DCache (port 1).
- Picks one requester, locks the grant for the whole burst (up to MLEN16 beats), forwards its request, and routes responses back to it only.
- Sits between the L1 caches and the cbus-to-AXI bridge.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- IDX_BITS, $clog2(NUM_REQ), width of the grant index (derived, not overridden).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- ireqs  in  NUM_REQ x cbus_req_t  per-requester cbus requests.
- iresps  out  NUM_REQ x cbus_resp_t  per-requester responses.
- oreq  out  cbus_req_t  request to the shared bus.
- oresp  in  cbus_resp_t  response from the shared bus.
- busy  out  1  high while a grant is held.

Behaviour:
- States: IDLE, BUSY. Registers: state, index (IDX_BITS), last_grant (IDX_BITS).
- Reset (resetn low at posedge): state=IDLE, index=0, last_grant=NUM_REQ-1.
- During reset, and whenever state is IDLE: oreq='0, every iresps[k]='0, busy=0.
- IDLE:
  - Choose a winner combinationally among requesters with valid=1. Default policy is fixed priority (see Optional Feature).
  - At the next posedge: index<=winner, state<=BUSY.
  - With no valid request, stay in IDLE.
  - Arbitration latency is 1 cycle. The first beat can handshake in the cycle after the request is first seen.
- BUSY:
  - oreq = ireqs[index], forwarded combinationally; busy=1.
  - iresps[index] = oresp; every other iresps[k]='0. Losers see ready=0 and stall.
  - On oresp.ready && oresp.last: state<=IDLE, last_grant<=index.
  - If ireqs[index].valid=0 with no handshake in that cycle (requester abandoned the burst): state<=IDLE, last_grant unchanged. oreq.valid is 0 in that cycle.
- Mandatory bubble: after the last beat there is always one IDLE cycle, even when other requests are pending. This guarantees a requester never sees a stale grant while dropping valid.
- Requester contract: hold ireqs[k] stable from valid rise until ready&&last. The arbiter does not register request fields.
- Simultaneous requests in IDLE: exactly one winner; the others wait with zero response.
- Write bursts: the data and strobe of each beat come from the granted requester unmodified. The arbiter never alters len, size, addr or is_write.
- Reset mid-burst: returns to IDLE in the next cycle. Outputs are zero from that cycle on. No beats are replayed.
- oresp.ready while in IDLE is ignored (not routed anywhere).

Optional Feature:
- Macro: CBUS_ARB_ROUND_ROBIN_EN.
- Defined: round-robin winner selection. Search starts at (last_grant+1) mod NUM_REQ and wraps; the first valid requester wins.
- Undefined: fixed priority; the highest-numbered valid requester wins, so DCache beats ICache. last_grant is still maintained but unused.

Decomposition:
- Shared package (common.svh):
  - cbus_req_t and cbus_resp_t (existing).
  - New arb_state_t enum {IDLE, BUSY}.
  - Local constant for the IDX_BITS width.
- One natural sub-module: cbus_arb_pick.
  - Combinational; inputs: valid vector and last_grant; outputs: winner and any_valid.
  - Contains both policies, selected by the macro.
- The FSM and muxing stay in cbus_arbiter.

Test Plan:
- Single read: ireqs[0] read addr 0x8000_0000, MLEN4; bus returns 4 beats 0x11..0x44 with ready each cycle.
  - Expected: busy rises 1 cycle after valid; iresps[0] gets 4 beats, last on the 4th; one IDLE cycle follows; iresps[1] stays 0 throughout.
- Collision, fixed priority: ireqs[0] and ireqs[1] valid in the same cycle, MLEN4 each.
  - Expected: port 1 served first; then 1 bubble; then port 0 served; total 10 cycles with ready always high.
- Collision, CBUS_ARB_ROUND_ROBIN_EN: both ports continuously valid for 3 bursts.
  - Expected: grant order 0,1,0 from reset (last_grant=1 at reset).
- Write burst with bus stalls: port 1 writes MLEN4, strobe 4'b1111, data 0xA0..0xA3; bus inserts ready=0 for 2 cycles before beat 3.
  - Expected: oreq equals ireqs[1] exactly in every BUSY cycle; state stays BUSY through the stall.
- Abandon: port 0 drops valid after beat 1 of MLEN4.
  - Expected: next cycle IDLE with oreq.valid=0; a pending port 1 request is granted the following cycle.
- Reset during beat 2 of a port-0 burst.
  - Expected: outputs are 0 in the cycle after reset is sampled; state=IDLE; index=0.
